// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: single-slot ID stage with load-use bubble, CSR drain serialisation and redirect flush
module decode_issue_ctrl #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  input  logic             id_ready,
  input  logic             pipe_empty,
  input  logic             redirect,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, FULL, LU, CSR} state_t;
  state_t state, state_nx;
  logic accept, issue, hazard, rs1_rd, rs2_rd;
  logic [4:0] op_in, rd_id;
  assign op_in = if_inst[6:2];
  assign rd_id = id_inst[11:7];
  assign issue = state == FULL && id_ready && !redirect;
  assign accept = if_valid && if_ready;
  assign rs1_rd = !(op_in == 5'b01101 || op_in == 5'b00101 || op_in == 5'b11011 ||
                   (op_in == 5'b11100 && if_inst[14]));
  assign rs2_rd = op_in == 5'b01100 || op_in == 5'b01000 || op_in == 5'b11000;
  assign hazard = issue && id_inst[6:2] == 5'b00000 && rd_id != 5'd0 &&
                  ((rs1_rd && if_inst[19:15] == rd_id) || (rs2_rd && if_inst[24:20] == rd_id));
  // handshake outputs and next state; redirect overrides everything
  always_comb begin
    id_valid = state == FULL && !redirect;
    if_ready = !redirect && (state == EMPTY || (state == FULL && id_ready));
    state_nx = redirect                   ? EMPTY :
               accept                     ? (op_in == 5'b11100 ? CSR : hazard ? LU : FULL) :
               state == FULL && id_ready  ? EMPTY :
               state == LU                ? FULL :
               state == CSR && pipe_empty ? FULL : state;
  end
  // slot registers and saturating bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      id_inst   <= RESET_INST;
      id_pc     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        id_inst <= RESET_INST;
        id_pc   <= '0;
      end else if (accept) begin
        id_inst <= if_inst;
        id_pc   <= if_pc;
      end
      if ((state == LU || state == CSR) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule
